// File: rtl/entry_pkg.sv
// Shared definitions for the DRSSTC configuration-input block.
// Holds parameter defaults, the receiver state type and ASCII helpers.
package entry_pkg;

    localparam int DEF_CONF_PAR_MAX = 8;
    localparam int DEF_CONF_PAR_4 = 5;
    localparam int DEF_CLKS_PER_BIT = 16;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_START = 3'd1,
        RX_DATA = 3'd2,
        RX_STOP = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, framing FSM, bit/cycle counters.
// Ports: clk, rst_n, rx (async line), data[7:0], valid (1-cycle, mid stop bit).
module uart_rx
    import entry_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          meta;
    logic          line;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          at_half;
    logic          at_full;

    assign at_half = (cnt == HALF_LAST);
    assign at_full = (cnt == FULL_LAST);

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            line <= 1'b1;
        end else begin
            meta <= rx;
            line <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
        end else begin
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!line) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (at_half) begin
                        cnt <= '0;
                        bit_idx <= '0;
                        // High at mid-start means it was a glitch.
                        state <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (at_full) begin
                        cnt <= '0;
                        shift[bit_idx] <= line;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (at_full) begin
                        cnt <= '0;
                        // A low stop bit may be a break; wait for idle.
                        state <= line ? RX_IDLE : RX_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    cnt <= '0;
                    if (line) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Valid in the mid-stop sample cycle so the consumer's
    // register edge is the only extra cycle of latency.
    assign valid = (state == RX_STOP) && at_full && line;
    assign data = shift;

endmodule

// File: rtl/entry.sv
// DRSSTC configuration input: UART bytes pushed into a parameter shift register.
// Ports: clk, rst_n, uart_data (async RX), sh_reg[DEPTH][W] (0 = newest),
// is_data_ready (1-cycle push pulse). Option: ENTRY_ASCII_DECODE_EN.
module entry
    import entry_pkg::*;
#(
    parameter int CONF_PAR_MAX = DEF_CONF_PAR_MAX,
    parameter int CONF_PAR_4 = DEF_CONF_PAR_4,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    uart_data,
    output logic [CONF_PAR_4-1:0][CONF_PAR_MAX-1:0] sh_reg,
    output logic                                    is_data_ready
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       accept;
    logic [7:0] value;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .rx(uart_data),
        .data(rx_data),
        .valid(rx_valid)
    );

`ifdef ENTRY_ASCII_DECODE_EN
    // Only decimal digits carry configuration; everything else is dropped.
    assign accept = rx_valid && is_digit(rx_data);
    assign value = rx_data - ASCII_ZERO;
`else
    assign accept = rx_valid;
    assign value = rx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg <= '0;
            is_data_ready <= 1'b0;
        end else begin
            is_data_ready <= accept;
            if (accept) begin
                for (int i = CONF_PAR_4 - 1; i > 0; i--) begin
                    sh_reg[i] <= sh_reg[i-1];
                end
                sh_reg[0] <= CONF_PAR_MAX'(value);
            end
        end
    end

endmodule

// File: tb/tb_entry.sv
// Scoreboard bench for entry: UART frames driven, expected pushes queued.
// Works with or without ENTRY_ASCII_DECODE_EN.
module tb_entry;

    localparam int W = 8;
    localparam int D = 5;
    localparam int CPB = 16;

    logic                clk;
    logic                rst_n;
    logic                uart_data;
    logic [D-1:0][W-1:0] sh_reg;
    logic                is_data_ready;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model[D];

    entry #(
        .CONF_PAR_MAX(W),
        .CONF_PAR_4(D),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_data(uart_data),
        .sh_reg(sh_reg),
        .is_data_ready(is_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result of a valid frame: {accepted, pushed value}.
    function automatic logic [8:0] model_byte(input logic [7:0] b);
`ifdef ENTRY_ASCII_DECODE_EN
        if (b >= 8'h30 && b <= 8'h39) return {1'b1, b - 8'h30};
        return {1'b0, 8'h00};
`else
        return {1'b1, b};
`endif
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < D; i++) begin
            check(tag, sh_reg[i], model[i]);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < D; i++) model[i] = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [8:0] m;
        m = model_byte(b);
        if (stop && m[8]) exp_q.push_back(m[7:0]);
        uart_data = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_data = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_data = stop;
        repeat (CPB) @(posedge clk);
        uart_data = 1'b1;
        if (!stop) repeat (CPB) @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Pop and compare on every push pulse.
    always @(negedge clk) begin
        if (rst_n && is_data_ready) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("spurious_push", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                for (int i = D - 1; i > 0; i--) model[i] = model[i-1];
                model[0] = e;
                check("push_new", sh_reg[0], e);
                check_all("push_reg");
            end
        end
    end

    initial begin
        logic [7:0] v4, v2;
        int p0;
        uart_data = 1'b1;
        rst_n = 1'b0;
        clear_model();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset asserted while idle.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all("rst_sh");
        check("rst_rdy", is_data_ready, 0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // 42424 back-to-back.
        p0 = pulses;
        send_frame(8'h34, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h34, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h34, 1'b1);
        drain();
        @(negedge clk);
        check("42424_pulses", pulses - p0, 5);
`ifdef ENTRY_ASCII_DECODE_EN
        v4 = 8'd4;
        v2 = 8'd2;
`else
        v4 = 8'h34;
        v2 = 8'h32;
`endif
        check("42424_0", sh_reg[0], v4);
        check("42424_1", sh_reg[1], v2);
        check("42424_2", sh_reg[2], v4);
        check("42424_3", sh_reg[3], v2);
        check("42424_4", sh_reg[4], v4);

        // Overflow: six bytes into five entries.
        for (int i = 1; i <= 6; i++) begin
            send_frame(8'h30 + 8'(i), 1'b1);
        end
        drain();
`ifdef ENTRY_ASCII_DECODE_EN
        check("ovf_new", sh_reg[0], 6);
        check("ovf_old", sh_reg[4], 2);
`else
        check("ovf_new", sh_reg[0], 8'h36);
        check("ovf_old", sh_reg[4], 8'h32);
`endif

        // Framing error then a good byte.
        send_frame(8'h55, 1'b0);
        send_frame(8'h41, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        check_all("frame_reg");

        // Short low glitch on an idle line.
        p0 = pulses;
        uart_data = 1'b0;
        repeat (CPB / 2 - 2) @(posedge clk);
        uart_data = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_pulses", pulses - p0, 0);
        check_all("glitch_hold");

        // Reset after four data bits of 0xA5.
        v4 = 8'hA5;
        uart_data = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_data = v4[i];
            repeat (CPB) @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        uart_data = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check_all("midrst_sh");
        check("midrst_rdy", is_data_ready, 0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        check_all("after_rst");
`ifndef ENTRY_ASCII_DECODE_EN
        check("after_rst_a5", sh_reg[0], 8'hA5);
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entry.md
Name: entry

Overview:
- Top-level configuration-input block of the DRSSTC controller.
- Receives an asynchronous serial byte stream (UART 8N1, LSB first) on a single line.
- Pushes each valid received byte into a DEPTH-entry parameter shift register, which is exposed as a 2-D output bus for the rest of the controller.

Parameters:
- CONF_PAR_MAX, 8: width in bits of each shift-register entry (must be ≥ 8).
- CONF_PAR_4, 5: number of shift-register entries (DEPTH).
- CLKS_PER_BIT, 16: system clock cycles per UART bit period (≥ 4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_data  input  1  asynchronous UART RX line; idle high.
- sh_reg  output  CONF_PAR_4 x CONF_PAR_MAX  parameter shift register; sh_reg[0] is the newest entry.
- is_data_ready  output  1  one-cycle pulse when a byte is pushed into sh_reg.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all sh_reg entries 0; is_data_ready 0.
  - FSM in IDLE; bit and cycle counters 0.
  - synchronizer flops preset to 1.
- uart_data passes through a 2-flop synchronizer before use. All timing below is measured from the synchronized signal.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: synchronized line = 0 → START, cycle counter cleared.
- START:
  - after CLKS_PER_BIT/2 cycles, sample the line.
  - 0 → DATA, bit index 0, counter cleared.
  - 1 → glitch, return to IDLE.
- DATA:
  - every CLKS_PER_BIT cycles (mid-bit), sample into byte[bit index], LSB first.
  - after bit 7 → STOP.
- STOP: after CLKS_PER_BIT cycles, sample the line.
  - 1 → byte valid: push and pulse, then IDLE.
  - 0 → framing error: byte discarded, no push, → WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line = 1, then IDLE. This prevents false starts on a break condition.
- Push, in one cycle:
  - sh_reg[i] ← sh_reg[i-1] for i = DEPTH-1 down to 1.
  - sh_reg[0] ← byte, zero-extended to CONF_PAR_MAX.
  - the oldest entry is dropped.
- is_data_ready is high exactly in the cycle the push takes effect.
- Latency: push occurs at the mid-point of the stop bit, plus 2 synchronizer cycles, plus 1 register cycle.
- Back-to-back frames (stop immediately followed by start) must be received without loss.
- Reset mid-frame aborts the frame; no partial byte is ever pushed.
- sh_reg holds its value between pushes indefinitely.

Optional Feature:
- Macro: ENTRY_ASCII_DECODE_EN.
- Defined:
  - bytes 0x30–0x39 ('0'–'9') are pushed as the numeric value 0–9.
  - all other valid bytes are discarded: no push, no is_data_ready.
- Undefined: every valid byte is pushed raw.

Decomposition:
- Package entry_pkg holds:
  - CONF_PAR_MAX / CONF_PAR_4 / CLKS_PER_BIT defaults.
  - the rx state enum typedef.
  - the ASCII '0' constant (0x30).
- One sub-module, uart_rx, contains the synchronizer, FSM and counters. Its outputs are an 8-bit data bus and a valid pulse.
- entry instantiates uart_rx and owns the shift register and the optional decode stage.

Test Plan:
- Reset: assert rst_n=0 mid-idle → all sh_reg = 0, is_data_ready = 0.
- "42424" test (ASCII_DECODE off):
  - stimulus: frames 0x34, 0x32, 0x34, 0x32, 0x34 back-to-back.
  - response: sh_reg[0..4] = 0x34, 0x32, 0x34, 0x32, 0x34; exactly 5 is_data_ready pulses.
- Same stream with ENTRY_ASCII_DECODE_EN → sh_reg[0..4] = 4, 2, 4, 2, 4.
- Overflow: send 0x31..0x36 (six bytes), raw → sh_reg[0] = 0x36, sh_reg[4] = 0x32; 0x31 dropped.
- Framing and glitch:
  - byte 0x55 with stop bit = 0 → no push; next valid 0x41 → sh_reg[0] = 0x41.
  - a 0-pulse on the line shorter than CLKS_PER_BIT/2 → no reception.
- Reset mid-frame: assert rst_n after 4 data bits → sh_reg = 0; the following full frame 0xA5 is received correctly.
